ram_store_merge: RTL and testbench
==================================

RAM_STORE_MERGE -- requirements
Module: ram_store_merge

Interface
REQ-001 Parameter: RD_LAT, default 1, RAM read latency in cycles from a ram_re cycle to a valid ram_rdata; legal values are 1..3.
REQ-002 Port: clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  in  1  store request valid.
REQ-005 Port: req_ready  out  1  block can accept a request.
REQ-006 Port: req_addr  in  32  store byte address.
REQ-007 Port: req_data  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-008 Port: req_mask  in  ram_mask_e  store width: RAM_MASK_B, RAM_MASK_H or RAM_MASK_W.
REQ-009 Port: done  out  1  one-cycle pulse when a request completes.
REQ-010 Port: err  out  1  one-cycle pulse, coincident with done, for a misaligned request.
REQ-011 Port: ram_addr  out  32  word-aligned RAM address, {addr[31:2],2'b00}.
REQ-012 Port: ram_re  out  1  RAM read strobe.
REQ-013 Port: ram_rdata  in  32  RAM read data.
REQ-014 Port: ram_we  out  1  RAM write strobe; the RAM has no byte enables.
REQ-015 Port: ram_wdata  out  32  full-word write data.

Function
REQ-016 The block shall implement the store (write) side of the RAM mask: byte and halfword stores by read-modify-write; word stores by direct write.
REQ-017 FSM states shall be IDLE, READ, WAIT, WRITE and RESP.
REQ-018 req_ready shall be 1 only in IDLE; a handshake is req_valid && req_ready at a rising edge.
REQ-019 At the handshake, addr, data and mask shall be latched; later input changes shall be ignored until the next IDLE.
REQ-020 Any req_mask value outside B/H/W shall be treated as RAM_MASK_W.
REQ-021 Misaligned requests are: H with addr[0]=1, or W with addr[1:0]!=0.
REQ-022 Misaligned path: IDLE->RESP; in cycle N+1 (N = handshake cycle) done=1 and err=1; ram_re and ram_we stay 0 throughout.
REQ-023 Aligned W path: IDLE->WRITE; in cycle N+1 ram_we=1, ram_wdata=data and done=1.
REQ-024 Aligned B/H path: IDLE->READ; in cycle N+1 ram_re=1.
REQ-025 B/H path, WAIT: WAIT shall last RD_LAT cycles (N+2..N+1+RD_LAT); ram_rdata shall be captured on the final WAIT edge.
REQ-026 B/H path, WRITE: in cycle N+2+RD_LAT ram_we=1, ram_wdata=merged word and done=1.
REQ-027 B merge: byte lane addr[1:0] (lane k = bits [8k+7:8k]) shall be replaced with data[7:0]; the other lanes keep the read data.
REQ-028 H merge: half lane addr[1] (bits [16h+15:16h]) shall be replaced with data[15:0]; the other half keeps the read data.
REQ-029 WRITE and RESP shall return to IDLE after one cycle, so a back-to-back request is accepted no earlier than the edge ending the done cycle +1.
REQ-030 ram_re, ram_we, done and err shall each be high for exactly one cycle per request, and never all of them simultaneously.
REQ-031 ram_addr shall hold the latched aligned address from the handshake until the next handshake.
REQ-032 An RD_LAT counter shall be used; no combinational path shall exist from req_* to ram_*.

Reset
REQ-033 rst_n=0 shall immediately force IDLE and set req_ready=1, done=0, err=0, ram_re=0, ram_we=0, ram_addr=0, ram_wdata=0, with no partial write.
REQ-034 Reset asserted mid-operation (READ/WAIT/WRITE) shall abort the request with no done pulse; after reset release the block shall accept a new request.

Verification
REQ-035 Word store: W, addr 0x100, data 0xDEADBEEF -> cycle N+1: ram_we=1, ram_addr=0x100, ram_wdata=0xDEADBEEF, done=1, err=0, ram_re never 1.
REQ-036 Byte store, RD_LAT=1: B, addr 0x102, data 0x000000AB, RAM word 0x11223344 -> ram_re at N+1, ram_we at N+3 with ram_wdata=0x11AB3344, done=1.
REQ-037 Half store, RD_LAT=3: H, addr 0x206, data 0x0000CAFE, RAM word 0x55667788 -> ram_we at N+5, ram_wdata=0xCAFE7788.
REQ-038 Misaligned requests: H at 0x101 and W at 0x102 -> done=err=1 at N+1; no ram_re or ram_we.
REQ-039 Reset during WAIT: rst_n low -> ram_we never asserted for that request; req_ready=1 immediately; a following W store completes normally.
REQ-040 Input stability: change req_data/req_addr while in READ -> written word reflects only the latched values; req_ready stays 0 until IDLE.

Source files
------------

// File: rtl/ram_store_merge_if.sv
// ============================================================================
// ram_store_merge_if : store-request bus and word-wide RAM port of ram_store_merge
// Rev 1.0
// ============================================================================
`default_nettype none

package ram_store_merge_pkg;
  typedef enum logic [1:0] {
    RAM_MASK_B = 2'b00,
    RAM_MASK_H = 2'b01,
    RAM_MASK_W = 2'b10
  } ram_mask_e;
endpackage

interface ram_store_merge_if;
  import ram_store_merge_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  ram_mask_e   req_mask;
  logic        done;
  logic        err;
  logic [31:0] ram_addr;
  logic        ram_re;
  logic [31:0] ram_rdata;
  logic        ram_we;
  logic [31:0] ram_wdata;

  // master = requester plus RAM model; slave = the merge block
  modport master (
    output req_valid, req_addr, req_data, req_mask, ram_rdata,
    input  req_ready, done, err, ram_addr, ram_re, ram_we, ram_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_mask, ram_rdata,
    output req_ready, done, err, ram_addr, ram_re, ram_we, ram_wdata
  );
endinterface

`default_nettype wire

// File: rtl/ram_store_merge.sv
// ============================================================================
// ram_store_merge : byte/half stores by read-modify-write, word stores direct
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_store_merge
  import ram_store_merge_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  ram_store_merge_if.slave   bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  localparam logic [1:0] C_LAT_M1 = 2'(RD_LAT - 1);

  logic [2:0]  state_q, state_d;
  logic [29:0] waddr_q, waddr_d;
  logic [1:0]  off_q,   off_d;
  logic        half_q,  half_d;
  logic [15:0] data_q,  data_d;
  logic [1:0]  cnt_q,   cnt_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merged;

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    off_d   = off_q;
    half_d  = half_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;

    // Only the addressed lane takes store data; the rest keeps the read word
    merged = bus.ram_rdata;
    if (half_q) begin
      merged[{off_q[1], 4'b0000} +: 16] = data_q;
    end else begin
      merged[{off_q, 3'b000} +: 8] = data_q[7:0];
    end

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          waddr_d = bus.req_addr[31:2];
          off_d   = bus.req_addr[1:0];
          data_d  = bus.req_data[15:0];
          half_d  = (bus.req_mask == RAM_MASK_H);
          case (bus.req_mask)
            RAM_MASK_B: state_d = READ;
            RAM_MASK_H: state_d = bus.req_addr[0] ? RESP : READ;
            default: begin
              if (bus.req_addr[1:0] != 2'b00) begin
                state_d = RESP;
              end else begin
                state_d = WRITE;
                wdata_d = bus.req_data;
              end
            end
          endcase
        end
      end
      READ: begin
        state_d = WAIT;
        cnt_d   = C_LAT_M1;
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          wdata_d = merged;
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      WRITE:   state_d = IDLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      waddr_q <= '0;
      off_q   <= '0;
      half_q  <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      off_q   <= off_d;
      half_q  <= half_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
    end
  end

  // All outputs decode registered state, so req_* never reaches ram_* combinationally
  assign bus.req_ready = (state_q == IDLE);
  assign bus.ram_re    = (state_q == READ);
  assign bus.ram_we    = (state_q == WRITE);
  assign bus.done      = (state_q == WRITE) || (state_q == RESP);
  assign bus.err       = (state_q == RESP);
  assign bus.ram_addr  = {waddr_q, 2'b00};
  assign bus.ram_wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_store_merge.sv
// ============================================================================
// tb_ram_store_merge : drives identical stores into RD_LAT=1 and RD_LAT=3 copies
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ram_store_merge;
  import ram_store_merge_pkg::*;

  typedef struct {
    logic [1:0]  mask;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] mem;
    logic [31:0] exp_wdata;
    int          kind;     // 0 misaligned, 1 direct word write, 2 read-modify-write
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        tb_valid;
  logic [31:0] tb_addr;
  logic [31:0] tb_data;
  logic [1:0]  tb_mask;
  logic [31:0] mem_word;
  logic [2:0]  pipe1;
  logic [2:0]  pipe3;
  int          tests;
  int          fails;

  ram_store_merge_if bus1 ();
  ram_store_merge_if bus3 ();

  assign bus1.req_valid = tb_valid;
  assign bus1.req_addr  = tb_addr;
  assign bus1.req_data  = tb_data;
  assign bus1.req_mask  = ram_mask_e'(tb_mask);
  assign bus3.req_valid = tb_valid;
  assign bus3.req_addr  = tb_addr;
  assign bus3.req_data  = tb_data;
  assign bus3.req_mask  = ram_mask_e'(tb_mask);

  // RAM models: read data is valid only in the cycle RD_LAT after ram_re
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe1 <= '0;
      pipe3 <= '0;
    end else begin
      pipe1 <= {pipe1[1:0], bus1.ram_re};
      pipe3 <= {pipe3[1:0], bus3.ram_re};
    end
  end
  assign bus1.ram_rdata = pipe1[0] ? mem_word : 32'hBAD0_BAD0;
  assign bus3.ram_rdata = pipe3[2] ? mem_word : 32'hBAD0_BAD0;

  ram_store_merge #(.RD_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  ram_store_merge #(.RD_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v, input int id);
    int re_c[2], we_c[2], dn_c[2], er_c[2], npulse[2];
    logic [31:0] wd[2];
    logic [31:0] a1[2];
    logic [31:0] exp_addr;
    int lat;
    int e_re, e_we, e_dn, e_er;
    for (int d = 0; d < 2; d++) begin
      re_c[d] = 0; we_c[d] = 0; dn_c[d] = 0; er_c[d] = 0; npulse[d] = 0;
      wd[d] = '0; a1[d] = '0;
    end
    exp_addr = {v.addr[31:2], 2'b00};
    @(negedge clk);
    chk($sformatf("v%0d ready_before lat1", id), {31'd0, bus1.req_ready}, 32'd1);
    chk($sformatf("v%0d ready_before lat3", id), {31'd0, bus3.req_ready}, 32'd1);
    mem_word = v.mem;
    tb_valid = 1'b1;
    tb_addr  = v.addr;
    tb_data  = v.data;
    tb_mask  = v.mask;
    @(posedge clk);
    #1;
    // Scramble request inputs: results must depend only on the latched values
    tb_valid = 1'b0;
    tb_addr  = 32'hFFFF_FFFF;
    tb_data  = 32'h5555_5555;
    tb_mask  = 2'b00;
    for (int c = 1; c <= 10; c++) begin
      logic re[2], we[2], dn[2], er[2];
      logic [31:0] wdv[2], av[2];
      @(negedge clk);
      re[0] = bus1.ram_re; we[0] = bus1.ram_we; dn[0] = bus1.done; er[0] = bus1.err;
      wdv[0] = bus1.ram_wdata; av[0] = bus1.ram_addr;
      re[1] = bus3.ram_re; we[1] = bus3.ram_we; dn[1] = bus3.done; er[1] = bus3.err;
      wdv[1] = bus3.ram_wdata; av[1] = bus3.ram_addr;
      if (c == 1) begin
        chk($sformatf("v%0d ready_busy lat1", id), {31'd0, bus1.req_ready}, 32'd0);
        chk($sformatf("v%0d ready_busy lat3", id), {31'd0, bus3.req_ready}, 32'd0);
      end
      for (int d = 0; d < 2; d++) begin
        if (re[d]) begin npulse[d]++; if (re_c[d] == 0) re_c[d] = c; end
        if (we[d]) begin npulse[d]++; if (we_c[d] == 0) begin we_c[d] = c; wd[d] = wdv[d]; end end
        if (dn[d]) begin npulse[d]++; if (dn_c[d] == 0) dn_c[d] = c; end
        if (er[d]) begin npulse[d]++; if (er_c[d] == 0) er_c[d] = c; end
        if (c == 1) a1[d] = av[d];
        if (c == 10) chk($sformatf("v%0d addr_hold d%0d", id, d), av[d], exp_addr);
      end
    end
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 1 : 3;
      e_re = 0; e_we = 0; e_dn = 0; e_er = 0;
      case (v.kind)
        0: begin e_dn = 1; e_er = 1; end
        1: begin e_we = 1; e_dn = 1; end
        default: begin e_re = 1; e_we = 2 + lat; e_dn = 2 + lat; end
      endcase
      chk($sformatf("v%0d lat%0d re_cycle", id, lat), re_c[d], e_re);
      chk($sformatf("v%0d lat%0d we_cycle", id, lat), we_c[d], e_we);
      chk($sformatf("v%0d lat%0d done_cycle", id, lat), dn_c[d], e_dn);
      chk($sformatf("v%0d lat%0d err_cycle", id, lat), er_c[d], e_er);
      chk($sformatf("v%0d lat%0d pulse_count", id, lat), npulse[d],
          (e_re != 0 ? 1 : 0) + (e_we != 0 ? 1 : 0) + (e_dn != 0 ? 1 : 0) + (e_er != 0 ? 1 : 0));
      chk($sformatf("v%0d lat%0d ram_addr", id, lat), a1[d], exp_addr);
      if (v.kind != 0) chk($sformatf("v%0d lat%0d wdata", id, lat), wd[d], v.exp_wdata);
    end
  endtask

  initial begin
    vec_t vecs[12];
    int bad_we, bad_done;
    tests = 0; fails = 0;
    tb_valid = 1'b0; tb_addr = '0; tb_data = '0; tb_mask = 2'b10; mem_word = '0;

    vecs[0]  = '{2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1};
    vecs[1]  = '{2'b00, 32'h0000_0102, 32'h0000_00AB, 32'h1122_3344, 32'h11AB_3344, 2};
    vecs[2]  = '{2'b01, 32'h0000_0206, 32'h0000_CAFE, 32'h5566_7788, 32'hCAFE_7788, 2};
    vecs[3]  = '{2'b01, 32'h0000_0101, 32'h0000_1234, 32'h1122_3344, 32'h0000_0000, 0};
    vecs[4]  = '{2'b10, 32'h0000_0102, 32'h1234_5678, 32'h1122_3344, 32'h0000_0000, 0};
    vecs[5]  = '{2'b00, 32'h0000_0103, 32'hFFFF_FF5A, 32'h1122_3344, 32'h5A22_3344, 2};
    vecs[6]  = '{2'b00, 32'h0000_0200, 32'h1234_5677, 32'hAABB_CCDD, 32'hAABB_CC77, 2};
    vecs[7]  = '{2'b01, 32'h0000_0300, 32'hFFFF_1234, 32'hAABB_CCDD, 32'hAABB_1234, 2};
    vecs[8]  = '{2'b11, 32'h0000_0404, 32'h0102_0304, 32'h9999_9999, 32'h0102_0304, 1};
    vecs[9]  = '{2'b11, 32'h0000_0405, 32'h0102_0304, 32'h9999_9999, 32'h0000_0000, 0};
    vecs[10] = '{2'b00, 32'h8000_0101, 32'h0000_00EE, 32'h1122_3344, 32'h1122_EE44, 2};
    vecs[11] = '{2'b10, 32'h0000_0003, 32'hCAFE_F00D, 32'h0000_0000, 32'h0000_0000, 0};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", {31'd0, bus1.req_ready}, 32'd1);
    chk("reset outs", {28'd0, bus1.done, bus1.err, bus1.ram_re, bus1.ram_we}, 32'd0);
    chk("reset ram_addr", bus1.ram_addr, 32'd0);
    chk("reset ram_wdata", bus3.ram_wdata, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_req(vecs[i], i);

    // Reset while both copies sit in WAIT: request must be dropped silently
    @(negedge clk);
    mem_word = 32'h1122_3344;
    tb_valid = 1'b1; tb_addr = 32'h0000_0102; tb_data = 32'h0000_00AB; tb_mask = 2'b00;
    @(posedge clk);
    #1 tb_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait ready lat1", {31'd0, bus1.req_ready}, 32'd1);
    chk("rst_wait ready lat3", {31'd0, bus3.req_ready}, 32'd1);
    chk("rst_wait outs lat3", {28'd0, bus3.done, bus3.err, bus3.ram_re, bus3.ram_we}, 32'd0);
    chk("rst_wait wdata lat3", bus3.ram_wdata, 32'd0);
    bad_we = 0; bad_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) rst_n = 1'b1;
      if (bus1.ram_we || bus3.ram_we) bad_we++;
      if (bus1.done || bus3.done) bad_done++;
    end
    chk("rst_wait no_we", bad_we, 0);
    chk("rst_wait no_done", bad_done, 0);
    run_req(vecs[0], 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
